// File: rtl/iologic_tx_gearbox.sv
// iologic_tx_gearbox: transmit soft gearbox driving ODDR D0/D1 and TQ.
// Define TX_TRAIN_EN to add the TRAIN_REQ port and training pattern state.
module iologic_tx_gearbox #(
    parameter int          GEAR       = 4,
    parameter logic [15:0] IDLE_WORD  = 16'h0,
    parameter logic [15:0] TRAIN_WORD = 16'hA5,
    parameter int          TQ_HOLD    = 3
) (
    input  logic              SCLK,
    input  logic              RST,
    input  logic [2*GEAR-1:0] TXD,
    input  logic              TXD_VALID,
    output logic              TXD_READY,
`ifdef TX_TRAIN_EN
    input  logic              TRAIN_REQ,
`endif
    output logic              Q0,
    output logic              Q1,
    output logic              TQ,
    output logic              BUSY,
    output logic              UNDERRUN
);
    localparam int W  = 2 * GEAR;
    localparam int SW = (GEAR > 1) ? $clog2(GEAR) : 1;
    localparam logic [SW-1:0] LAST   = SW'(GEAR - 1);
    localparam logic [3:0]    HOLD   = 4'(TQ_HOLD);
    localparam logic [W-1:0]  IDLE_W = IDLE_WORD[W-1:0];

`ifdef TX_TRAIN_EN
    localparam logic [W-1:0] TRAIN_W = TRAIN_WORD[W-1:0];
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_TRAIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
    logic unused_train;
    assign unused_train = ^TRAIN_WORD;
`endif

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [W-1:0]  word_q, word_d;
    logic [3:0]    idle_q, idle_d;
    logic          tq_q, tq_d;
    logic          q0_q, q0_d;
    logic          q1_q, q1_d;
    logic          busy_q, busy_d;
    logic          und_q, und_d;
    logic          ready_q, ready_d;
    logic [W-1:0]  b0_q, b0_d;
    logic [W-1:0]  b1_q, b1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;
    logic          push;
    logic          last;
    logic [SW-1:0] nxt_slot;
    logic [1:0]    pair;

    assign push     = TXD_VALID & ready_q;
    assign last     = (slot_q == LAST);
    assign nxt_slot = last ? '0 : slot_q + SW'(1);

    // Next state, slot, current word and tristate hold tracking.
    always_comb begin
        state_d = state_q;
        slot_d  = nxt_slot;
        word_d  = word_q;
        idle_d  = idle_q;
        tq_d    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                word_d = IDLE_W;
                idle_d = (idle_q == 4'hF) ? idle_q : idle_q + 4'd1;
                tq_d   = tq_q | (idle_d >= HOLD);
`ifdef TX_TRAIN_EN
                if (TRAIN_REQ) begin
                    state_d = S_TRAIN;
                    slot_d  = '0;
                    word_d  = TRAIN_W;
                    tq_d    = 1'b0;
                end else
`endif
                if (cnt_q != 2'd0 && (last || idle_q >= HOLD)) begin
                    state_d = S_SHIFT;
                    slot_d  = '0;
                    word_d  = b0_q;
                    pop     = 1'b1;
                    tq_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                if (last) begin
`ifdef TX_TRAIN_EN
                    if (TRAIN_REQ) begin
                        state_d = S_TRAIN;
                        word_d  = TRAIN_W;
                    end else
`endif
                    if (cnt_q != 2'd0) begin
                        word_d = b0_q;
                        pop    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        word_d  = IDLE_W;
                        idle_d  = '0;
                        tq_d    = (HOLD == 4'd0);
                    end
                end
            end
`ifdef TX_TRAIN_EN
            S_TRAIN: begin
                if (last && !TRAIN_REQ) begin
                    if (cnt_q != 2'd0) begin
                        state_d = S_SHIFT;
                        word_d  = b0_q;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        word_d  = IDLE_W;
                        idle_d  = '0;
                        tq_d    = (HOLD == 4'd0);
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                slot_d  = '0;
                word_d  = IDLE_W;
                idle_d  = '0;
                tq_d    = 1'b1;
            end
        endcase
    end

    // Two-entry word buffer; push and pop on one edge keep occupancy.
    always_comb begin
        b0_d  = b0_q;
        b1_d  = b1_q;
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) b0_d = TXD;
                else               b1_d = TXD;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                b0_d  = b1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    b0_d = TXD;
                end else begin
                    b0_d = b1_q;
                    b1_d = TXD;
                end
            end
            default: ;
        endcase
    end

    // Registered output values derived from the next state.
    always_comb begin
        pair    = 2'(word_d >> {slot_d, 1'b0});
        q0_d    = pair[0];
        q1_d    = pair[1];
        busy_d  = (state_d != S_IDLE);
        und_d   = (state_d == S_SHIFT) && (slot_d == LAST) &&
                  (cnt_d == 2'd0);
        ready_d = (cnt_d != 2'd2);
    end

    // State and output registers; reset flushes everything.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            word_q  <= '0;
            idle_q  <= '0;
            tq_q    <= 1'b1;
            q0_q    <= 1'b0;
            q1_q    <= 1'b0;
            busy_q  <= 1'b0;
            und_q   <= 1'b0;
            ready_q <= 1'b0;
            b0_q    <= '0;
            b1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            word_q  <= word_d;
            idle_q  <= idle_d;
            tq_q    <= tq_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            busy_q  <= busy_d;
            und_q   <= und_d;
            ready_q <= ready_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Q0        = q0_q;
    assign Q1        = q1_q;
    assign TQ        = tq_q;
    assign BUSY      = busy_q;
    assign UNDERRUN  = und_q;
    assign TXD_READY = ready_q;

endmodule
